// File: rtl/wb_regfile_pkg.sv
// -----------------------------------------------------------------------------
// wb_regfile_pkg
// Shared constants for the write-back stage / register file slice.
//   REG_NUM_D, DATA_W_D, ADDR_W_D : default geometry (32 x 32-bit, 5-bit addr)
//   ZERO_WORD, NOP_REG_ADDR       : cleared data word / idle register address
//   RST_ENABLE, WRITE_ENABLE,
//   READ_ENABLE                   : active levels of the control strobes
// Optional feature macro used by this slice: REG_BYPASS_EN.
// -----------------------------------------------------------------------------
package wb_regfile_pkg;

    localparam int REG_NUM_D = 32;
    localparam int DATA_W_D  = 32;
    localparam int ADDR_W_D  = 5;

    localparam logic [DATA_W_D-1:0] ZERO_WORD    = '0;
    localparam logic [ADDR_W_D-1:0] NOP_REG_ADDR = '0;

    localparam logic RST_ENABLE   = 1'b1;
    localparam logic WRITE_ENABLE = 1'b1;
    localparam logic READ_ENABLE  = 1'b1;

endpackage

// File: rtl/wb_regfile_array.sv
// -----------------------------------------------------------------------------
// wb_regfile_array
// Register storage: REG_NUM x DATA_W array, one synchronous write port and two
// combinational read ports. Register 0 is never written and always reads zero.
// Ports:
//   clk, rst             : clock, synchronous active-high reset (clears array)
//   i_we/i_waddr/i_wdata : write strobe, target, data (commit from the top)
//   i_raddr1, i_raddr2   : read addresses
//   o_rdata1, o_rdata2   : raw array read data (r0 forced to zero)
// -----------------------------------------------------------------------------
module wb_regfile_array
    import wb_regfile_pkg::*;
#(
    parameter int REG_NUM = REG_NUM_D,
    parameter int DATA_W  = DATA_W_D,
    parameter int ADDR_W  = ADDR_W_D
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr1,
    input  logic [ADDR_W-1:0] i_raddr2,
    output logic [DATA_W-1:0] o_rdata1,
    output logic [DATA_W-1:0] o_rdata2
);

    logic [DATA_W-1:0] r_mem [REG_NUM];

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            for (int i = 0; i < REG_NUM; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we == WRITE_ENABLE && i_waddr != '0) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = (i_raddr1 == '0) ? '0 : r_mem[i_raddr1];
    assign o_rdata2 = (i_raddr2 == '0) ? '0 : r_mem[i_raddr2];

endmodule

// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile
// Write-back stage plus general-purpose register file. The upstream write
// request is captured in a one-entry write-back latch and committed into the
// array on the following edge; two combinational read ports feed decode.
// Optional feature: define REG_BYPASS_EN to forward the incoming request and
// the pending latch entry onto the read ports (incoming has priority).
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   stall_i, flush_i               : hold / discard the write-back latch
//   waddr_reg_i, we_reg_i, wdata_i : upstream write request
//   re1_i/raddr1_i, re2_i/raddr2_i : read enables and addresses
//   rdata1_o, rdata2_o             : combinational read data
//   wb_we_o, wb_waddr_o, wb_wdata_o: current latch contents (commit trace)
//   commit_cnt_o                   : number of commits to nonzero registers
// -----------------------------------------------------------------------------
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int REG_NUM = REG_NUM_D,
    parameter int DATA_W  = DATA_W_D,
    parameter int ADDR_W  = ADDR_W_D
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] waddr_reg_i,
    input  logic              we_reg_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re1_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    input  logic              re2_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata1_o,
    output logic [DATA_W-1:0] rdata2_o,
    output logic              wb_we_o,
    output logic [ADDR_W-1:0] wb_waddr_o,
    output logic [DATA_W-1:0] wb_wdata_o,
    output logic [31:0]       commit_cnt_o
);

    logic              r_wb_we;
    logic [ADDR_W-1:0] r_wb_waddr;
    logic [DATA_W-1:0] r_wb_wdata;
    logic [31:0]       r_commit_cnt;

    logic              w_commit;
    logic [DATA_W-1:0] w_arr_rdata1;
    logic [DATA_W-1:0] w_arr_rdata2;

    // A pending entry commits only on a free-running edge: stall freezes it,
    // flush and reset throw it away.
    assign w_commit = (r_wb_we == WRITE_ENABLE) && (r_wb_waddr != '0) &&
                      !stall_i && !flush_i && (rst != RST_ENABLE);

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE || flush_i) begin
            r_wb_we    <= 1'b0;
            r_wb_waddr <= NOP_REG_ADDR;
            r_wb_wdata <= ZERO_WORD;
        end else if (!stall_i) begin
            r_wb_we    <= we_reg_i;
            r_wb_waddr <= waddr_reg_i;
            r_wb_wdata <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            r_commit_cnt <= '0;
        end else if (w_commit) begin
            r_commit_cnt <= r_commit_cnt + 32'd1;
        end
    end

    wb_regfile_array #(
        .REG_NUM (REG_NUM),
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .i_we     (w_commit),
        .i_waddr  (r_wb_waddr),
        .i_wdata  (r_wb_wdata),
        .i_raddr1 (raddr1_i),
        .i_raddr2 (raddr2_i),
        .o_rdata1 (w_arr_rdata1),
        .o_rdata2 (w_arr_rdata2)
    );

    function automatic logic [DATA_W-1:0] read_port(
        input logic              re,
        input logic [ADDR_W-1:0] raddr,
        input logic [DATA_W-1:0] arr_data
    );
        logic [DATA_W-1:0] v;
        v = arr_data;
`ifdef REG_BYPASS_EN
        // Incoming request is younger than the latch, so it wins; a stalled
        // request is not going anywhere and must not be forwarded.
        if (we_reg_i == WRITE_ENABLE && waddr_reg_i == raddr && !stall_i) begin
            v = wdata_i;
        end else if (r_wb_we == WRITE_ENABLE && r_wb_waddr == raddr) begin
            v = r_wb_wdata;
        end
`endif
        if (rst == RST_ENABLE || re != READ_ENABLE || raddr == '0) begin
            v = ZERO_WORD;
        end
        return v;
    endfunction

    always_comb begin
        rdata1_o = read_port(re1_i, raddr1_i, w_arr_rdata1);
        rdata2_o = read_port(re2_i, raddr2_i, w_arr_rdata2);
    end

    assign wb_we_o      = r_wb_we;
    assign wb_waddr_o   = r_wb_waddr;
    assign wb_wdata_o   = r_wb_wdata;
    assign commit_cnt_o = r_commit_cnt;

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        flush_i;
    logic [4:0]  waddr_reg_i;
    logic        we_reg_i;
    logic [31:0] wdata_i;
    logic        re1_i;
    logic [4:0]  raddr1_i;
    logic        re2_i;
    logic [4:0]  raddr2_i;
    logic [31:0] rdata1_o;
    logic [31:0] rdata2_o;
    logic        wb_we_o;
    logic [4:0]  wb_waddr_o;
    logic [31:0] wb_wdata_o;
    logic [31:0] commit_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: architectural registers, pending write, commit count.
    logic [31:0] m_regs [32];
    logic        m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [31:0] m_cnt;

    wb_regfile dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .waddr_reg_i  (waddr_reg_i),
        .we_reg_i     (we_reg_i),
        .wdata_i      (wdata_i),
        .re1_i        (re1_i),
        .raddr1_i     (raddr1_i),
        .re2_i        (re2_i),
        .raddr2_i     (raddr2_i),
        .rdata1_o     (rdata1_o),
        .rdata2_o     (rdata2_o),
        .wb_we_o      (wb_we_o),
        .wb_waddr_o   (wb_waddr_o),
        .wb_wdata_o   (wb_wdata_o),
        .commit_cnt_o (commit_cnt_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] exp_rd(input logic re, input logic [4:0] addr);
        if (rst || !re || addr == 5'd0) return 32'd0;
`ifdef REG_BYPASS_EN
        if (we_reg_i && waddr_reg_i == addr && !stall_i) return wdata_i;
        if (m_we && m_addr == addr) return m_data;
`endif
        return m_regs[addr];
    endfunction

    // Advance one clock edge and apply the architectural rules to the model.
    task automatic tick();
        logic c_rst, c_stall, c_flush, c_we;
        logic [4:0]  c_addr;
        logic [31:0] c_data;
        c_rst = rst; c_stall = stall_i; c_flush = flush_i;
        c_we = we_reg_i; c_addr = waddr_reg_i; c_data = wdata_i;
        @(posedge clk);
        if (c_rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            m_we = 1'b0; m_addr = 5'd0; m_data = 32'd0; m_cnt = 32'd0;
        end else begin
            if (m_we && m_addr != 5'd0 && !c_stall && !c_flush) begin
                m_regs[m_addr] = m_data;
                m_cnt = m_cnt + 32'd1;
            end
            if (c_flush) begin
                m_we = 1'b0; m_addr = 5'd0; m_data = 32'd0;
            end else if (!c_stall) begin
                m_we = c_we; m_addr = c_addr; m_data = c_data;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
        we_reg_i = 1'b1; waddr_reg_i = 5'd5; wdata_i = 32'hCAFE_0001;
        re1_i = 1'b1; raddr1_i = 5'd5; re2_i = 1'b1; raddr2_i = 5'd5;
        tick(); tick();
        #1;
        n_tests++;
        if (rdata1_o !== 32'd0) begin
            n_fail++; $display("FAIL reset_read_in_rst: got %h want 0", rdata1_o);
        end
        rst = 1'b0; we_reg_i = 1'b0; wdata_i = 32'd0;
        #1;
        n_tests++;
        if (rdata1_o !== 32'd0 || rdata2_o !== 32'd0) begin
            n_fail++; $display("FAIL reset_read_r5: got %h/%h want 0/0", rdata1_o, rdata2_o);
        end
        n_tests++;
        if (commit_cnt_o !== 32'd0) begin
            n_fail++; $display("FAIL reset_cnt: got %0d want 0", commit_cnt_o);
        end
        n_tests++;
        if (wb_we_o !== 1'b0 || wb_waddr_o !== 5'd0 || wb_wdata_o !== 32'd0) begin
            n_fail++; $display("FAIL reset_latch: got we=%b a=%0d d=%h want 0/0/0",
                               wb_we_o, wb_waddr_o, wb_wdata_o);
        end
    endtask

    task automatic test_write_commit();
        we_reg_i = 1'b1; waddr_reg_i = 5'd3; wdata_i = 32'h1234_5678;
        raddr1_i = 5'd3; raddr2_i = 5'd3;
        #1;
        n_tests++;
        if (rdata1_o !== exp_rd(1'b1, 5'd3)) begin
            n_fail++; $display("FAIL write_same_cycle: got %h want %h", rdata1_o, exp_rd(1'b1, 5'd3));
        end
        tick();
        n_tests++;
        if (wb_we_o !== 1'b1 || wb_waddr_o !== 5'd3 || wb_wdata_o !== 32'h1234_5678) begin
            n_fail++; $display("FAIL write_latched: got we=%b a=%0d d=%h want 1/3/12345678",
                               wb_we_o, wb_waddr_o, wb_wdata_o);
        end
        we_reg_i = 1'b0;
        tick();
        n_tests++;
        if (rdata1_o !== 32'h1234_5678 || rdata2_o !== 32'h1234_5678) begin
            n_fail++; $display("FAIL write_commit_r3: got %h/%h want 12345678", rdata1_o, rdata2_o);
        end
        n_tests++;
        if (commit_cnt_o !== 32'd1) begin
            n_fail++; $display("FAIL write_commit_cnt: got %0d want 1", commit_cnt_o);
        end
    endtask

    task automatic test_r0();
        we_reg_i = 1'b1; waddr_reg_i = 5'd0; wdata_i = 32'hFFFF_FFFF;
        raddr1_i = 5'd0;
        tick();
        we_reg_i = 1'b0;
        tick(); tick();
        n_tests++;
        if (rdata1_o !== 32'd0) begin
            n_fail++; $display("FAIL r0_read: got %h want 0", rdata1_o);
        end
        n_tests++;
        if (commit_cnt_o !== 32'd1) begin
            n_fail++; $display("FAIL r0_cnt: got %0d want 1", commit_cnt_o);
        end
    endtask

    task automatic test_flush_stall();
        raddr1_i = 5'd7; raddr2_i = 5'd7;
        we_reg_i = 1'b1; waddr_reg_i = 5'd7; wdata_i = 32'hA5A5_A5A5;
        tick();
        we_reg_i = 1'b0; flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        tick();
        n_tests++;
        if (rdata1_o !== 32'd0 || commit_cnt_o !== 32'd1) begin
            n_fail++; $display("FAIL flush_drop: got r7=%h cnt=%0d want 0/1", rdata1_o, commit_cnt_o);
        end
        we_reg_i = 1'b1;
        tick();
        we_reg_i = 1'b0; stall_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_tests++;
            if (rdata1_o !== exp_rd(1'b1, 5'd7) || commit_cnt_o !== 32'd1) begin
                n_fail++; $display("FAIL stall_hold_%0d: got r7=%h cnt=%0d want %h/1",
                                   k, rdata1_o, commit_cnt_o, exp_rd(1'b1, 5'd7));
            end
            tick();
        end
        stall_i = 1'b0;
        tick();
        n_tests++;
        if (rdata1_o !== 32'hA5A5_A5A5 || commit_cnt_o !== 32'd2) begin
            n_fail++; $display("FAIL stall_release: got r7=%h cnt=%0d want a5a5a5a5/2", rdata1_o, commit_cnt_o);
        end
        tick();
        n_tests++;
        if (commit_cnt_o !== 32'd2) begin
            n_fail++; $display("FAIL stall_single_commit: got %0d want 2", commit_cnt_o);
        end
        // Flush together with stall: flush wins, nothing commits.
        we_reg_i = 1'b1; waddr_reg_i = 5'd8; wdata_i = 32'h0000_0055;
        raddr1_i = 5'd8;
        tick();
        we_reg_i = 1'b0; stall_i = 1'b1; flush_i = 1'b1;
        tick();
        n_tests++;
        if (wb_we_o !== 1'b0 || wb_waddr_o !== 5'd0) begin
            n_fail++; $display("FAIL flush_over_stall: got we=%b a=%0d want 0/0", wb_we_o, wb_waddr_o);
        end
        stall_i = 1'b0; flush_i = 1'b0;
        tick();
        n_tests++;
        if (rdata1_o !== 32'd0 || commit_cnt_o !== 32'd2) begin
            n_fail++; $display("FAIL flush_over_stall_r8: got %h cnt=%0d want 0/2", rdata1_o, commit_cnt_o);
        end
    endtask

    task automatic test_reset_midop();
        we_reg_i = 1'b1; waddr_reg_i = 5'd11; wdata_i = 32'h0000_0077;
        raddr1_i = 5'd11; raddr2_i = 5'd3;
        tick();
        rst = 1'b1; we_reg_i = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        n_tests++;
        if (rdata1_o !== 32'd0 || rdata2_o !== 32'd0 || commit_cnt_o !== 32'd0) begin
            n_fail++; $display("FAIL reset_midop: got r11=%h r3=%h cnt=%0d want 0/0/0",
                               rdata1_o, rdata2_o, commit_cnt_o);
        end
    endtask

    task automatic test_back_to_back();
        raddr1_i = 5'd4; raddr2_i = 5'd4;
        we_reg_i = 1'b1; waddr_reg_i = 5'd4; wdata_i = 32'd1;
        tick();
        wdata_i = 32'd2;
        tick();
        we_reg_i = 1'b0;
        #1;
        n_tests++;
        if (rdata1_o !== exp_rd(1'b1, 5'd4) || commit_cnt_o !== 32'd1) begin
            n_fail++; $display("FAIL b2b_mid: got %h cnt=%0d want %h/1", rdata1_o, commit_cnt_o, exp_rd(1'b1, 5'd4));
        end
        tick();
        n_tests++;
        if (rdata1_o !== 32'd2 || commit_cnt_o !== 32'd2) begin
            n_fail++; $display("FAIL b2b_final: got %h cnt=%0d want 2/2", rdata1_o, commit_cnt_o);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_v;
        raddr1_i = 5'd9; raddr2_i = 5'd9;
        we_reg_i = 1'b1; waddr_reg_i = 5'd9; wdata_i = 32'hDEAD_BEEF;
        #1;
`ifdef REG_BYPASS_EN
        exp_v = 32'hDEAD_BEEF;
`else
        exp_v = 32'd0;
`endif
        n_tests++;
        if (rdata1_o !== exp_v || rdata2_o !== exp_v) begin
            n_fail++; $display("FAIL bypass_incoming: got %h/%h want %h", rdata1_o, rdata2_o, exp_v);
        end
        tick();
        we_reg_i = 1'b0;
        #1;
        n_tests++;
        if (rdata1_o !== exp_v) begin
            n_fail++; $display("FAIL bypass_latch: got %h want %h", rdata1_o, exp_v);
        end
        tick();
        n_tests++;
        if (rdata1_o !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL bypass_committed: got %h want deadbeef", rdata1_o);
        end
        we_reg_i = 1'b1; wdata_i = 32'd2;
        tick();
        wdata_i = 32'd1;
        #1;
`ifdef REG_BYPASS_EN
        exp_v = 32'd1;
`else
        exp_v = 32'hDEAD_BEEF;
`endif
        n_tests++;
        if (rdata1_o !== exp_v) begin
            n_fail++; $display("FAIL bypass_priority: got %h want %h", rdata1_o, exp_v);
        end
        stall_i = 1'b1;
        #1;
`ifdef REG_BYPASS_EN
        exp_v = 32'd2;
`else
        exp_v = 32'hDEAD_BEEF;
`endif
        n_tests++;
        if (rdata1_o !== exp_v) begin
            n_fail++; $display("FAIL bypass_stalled: got %h want %h", rdata1_o, exp_v);
        end
        re2_i = 1'b0;
        #1;
        n_tests++;
        if (rdata2_o !== 32'd0) begin
            n_fail++; $display("FAIL read_disabled: got %h want 0", rdata2_o);
        end
        re2_i = 1'b1; stall_i = 1'b0;
        tick();
        we_reg_i = 1'b0;
        tick();
        n_tests++;
        if (rdata1_o !== 32'd1 || commit_cnt_o !== 32'd5) begin
            n_fail++; $display("FAIL bypass_final: got %h cnt=%0d want 1/5", rdata1_o, commit_cnt_o);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 500; it++) begin
            rst         = ($urandom_range(0, 59) == 0);
            stall_i     = ($urandom_range(0, 4) == 0);
            flush_i     = ($urandom_range(0, 9) == 0);
            we_reg_i    = ($urandom_range(0, 3) != 0);
            waddr_reg_i = 5'($urandom_range(0, 7));
            wdata_i     = $urandom;
            re1_i       = ($urandom_range(0, 7) != 0);
            re2_i       = ($urandom_range(0, 7) != 0);
            raddr1_i    = 5'($urandom_range(0, 7));
            raddr2_i    = 5'($urandom_range(0, 7));
            #1;
            n_tests++;
            if (rdata1_o !== exp_rd(re1_i, raddr1_i) || rdata2_o !== exp_rd(re2_i, raddr2_i)) begin
                n_fail++; $display("FAIL rand_read it=%0d: got %h/%h want %h/%h", it,
                                   rdata1_o, rdata2_o, exp_rd(re1_i, raddr1_i), exp_rd(re2_i, raddr2_i));
            end
            tick();
            n_tests++;
            if (wb_we_o !== m_we || wb_waddr_o !== m_addr || wb_wdata_o !== m_data ||
                commit_cnt_o !== m_cnt) begin
                n_fail++; $display("FAIL rand_state it=%0d: got we=%b a=%0d d=%h cnt=%0d want %b/%0d/%h/%0d",
                                   it, wb_we_o, wb_waddr_o, wb_wdata_o, commit_cnt_o,
                                   m_we, m_addr, m_data, m_cnt);
            end
        end
        rst = 1'b0; stall_i = 1'b0; flush_i = 1'b0; we_reg_i = 1'b0;
        re1_i = 1'b1; re2_i = 1'b1;
        tick(); tick();
        for (int a = 0; a < 8; a++) begin
            raddr1_i = 5'(a);
            #1;
            n_tests++;
            if (rdata1_o !== m_regs[a]) begin
                n_fail++; $display("FAIL rand_final r%0d: got %h want %h", a, rdata1_o, m_regs[a]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_we = 1'b0; m_addr = 5'd0; m_data = 32'd0; m_cnt = 32'd0;
        test_reset();
        test_write_commit();
        test_r0();
        test_flush_stall();
        test_reset_midop();
        test_back_to_back();
        test_bypass();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
